// File: rtl/istisna_denetleyici.sv
// Trap/MRET sequencer: walks the CSR unit through mstatus/mepc/mcause/mtvec accesses one per cycle.
// Optional trap counter enabled with `define ISTISNA_SAYAC_EN.
module istisna_denetleyici #(
    parameter logic [1:0] MPP_DEGER = 2'b11
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        istisna_i,
    input  logic [3:0]  sebep_i,
    input  logic [31:1] ps_i,
    input  logic        mret_i,
    output logic [11:0] csr_adr_o,
    output logic        csr_yaz_o,
    output logic [31:0] csr_veri_o,
    input  logic [31:0] csr_deger_i,
    output logic        mesgul_o,
    output logic        ps_gecerli_o,
    output logic [31:1] ps_yeni_o,
    output logic [31:0] istisna_sayisi_o
);
    localparam logic [3:0] BOSTA         = 4'd0;
    localparam logic [3:0] T_MSTATUS_OKU = 4'd1;
    localparam logic [3:0] T_MEPC_YAZ    = 4'd2;
    localparam logic [3:0] T_MCAUSE_YAZ  = 4'd3;
    localparam logic [3:0] T_MSTATUS_YAZ = 4'd4;
    localparam logic [3:0] T_MTVEC_OKU   = 4'd5;
    localparam logic [3:0] R_MSTATUS_OKU = 4'd6;
    localparam logic [3:0] R_MSTATUS_YAZ = 4'd7;
    localparam logic [3:0] R_MEPC_OKU    = 4'd8;
    localparam logic [3:0] YONLENDIR     = 4'd9;

    localparam logic [11:0] ADR_MSTATUS = 12'h300;
    localparam logic [11:0] ADR_MTVEC   = 12'h305;
    localparam logic [11:0] ADR_MEPC    = 12'h341;
    localparam logic [11:0] ADR_MCAUSE  = 12'h342;

    logic [3:0]  durum;
    logic [3:0]  sebep_r;
    logic [31:1] ps_r;
    logic [31:0] mstatus_r;
    logic [31:1] hedef_r;
    logic [31:0] mstatus_tuzak;
    logic [31:0] mstatus_donus;
    logic        unused_ok;

    assign unused_ok = csr_deger_i[0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum     <= BOSTA;
            sebep_r   <= '0;
            ps_r      <= '0;
            mstatus_r <= '0;
            hedef_r   <= '0;
        end else begin
            case (durum)
                BOSTA: begin
                    // Exception wins over a simultaneous MRET; the MRET is dropped.
                    if (istisna_i) begin
                        sebep_r <= sebep_i;
                        ps_r    <= ps_i;
                        durum   <= T_MSTATUS_OKU;
                    end else if (mret_i) begin
                        durum   <= R_MSTATUS_OKU;
                    end
                end
                T_MSTATUS_OKU: begin
                    mstatus_r <= csr_deger_i;
                    durum     <= T_MEPC_YAZ;
                end
                T_MEPC_YAZ:    durum <= T_MCAUSE_YAZ;
                T_MCAUSE_YAZ:  durum <= T_MSTATUS_YAZ;
                T_MSTATUS_YAZ: durum <= T_MTVEC_OKU;
                T_MTVEC_OKU: begin
                    hedef_r <= {csr_deger_i[31:2], 1'b0};
                    durum   <= YONLENDIR;
                end
                R_MSTATUS_OKU: begin
                    mstatus_r <= csr_deger_i;
                    durum     <= R_MSTATUS_YAZ;
                end
                R_MSTATUS_YAZ: durum <= R_MEPC_OKU;
                R_MEPC_OKU: begin
                    hedef_r <= csr_deger_i[31:1];
                    durum   <= YONLENDIR;
                end
                default:       durum <= BOSTA;
            endcase
        end
    end

    always_comb begin
        mstatus_tuzak        = mstatus_r;
        mstatus_tuzak[7]     = mstatus_r[3];
        mstatus_tuzak[3]     = 1'b0;
        mstatus_tuzak[12:11] = MPP_DEGER;
        mstatus_donus        = mstatus_r;
        mstatus_donus[3]     = mstatus_r[7];
        mstatus_donus[7]     = 1'b1;
    end

    always_comb begin
        csr_adr_o  = '0;
        csr_yaz_o  = 1'b0;
        csr_veri_o = '0;
        case (durum)
            T_MSTATUS_OKU, R_MSTATUS_OKU: csr_adr_o = ADR_MSTATUS;
            T_MEPC_YAZ: begin
                csr_adr_o  = ADR_MEPC;
                csr_yaz_o  = 1'b1;
                csr_veri_o = {ps_r, 1'b0};
            end
            T_MCAUSE_YAZ: begin
                csr_adr_o  = ADR_MCAUSE;
                csr_yaz_o  = 1'b1;
                csr_veri_o = {28'b0, sebep_r};
            end
            T_MSTATUS_YAZ: begin
                csr_adr_o  = ADR_MSTATUS;
                csr_yaz_o  = 1'b1;
                csr_veri_o = mstatus_tuzak;
            end
            R_MSTATUS_YAZ: begin
                csr_adr_o  = ADR_MSTATUS;
                csr_yaz_o  = 1'b1;
                csr_veri_o = mstatus_donus;
            end
            T_MTVEC_OKU: csr_adr_o = ADR_MTVEC;
            R_MEPC_OKU:  csr_adr_o = ADR_MEPC;
            default: ;
        endcase
    end

    assign mesgul_o     = (durum != BOSTA);
    assign ps_gecerli_o = (durum == YONLENDIR);
    assign ps_yeni_o    = hedef_r;

`ifdef ISTISNA_SAYAC_EN
    logic [31:0] sayac;

    // A trap counts once its mstatus write has been issued.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            sayac <= '0;
        else if (durum == T_MSTATUS_YAZ)
            sayac <= sayac + 32'd1;
    end

    assign istisna_sayisi_o = sayac;
`else
    assign istisna_sayisi_o = '0;
`endif

endmodule

// File: tb/tb_istisna_denetleyici.sv
// Bench for istisna_denetleyici: CSR file modelled as an array, expected effects computed from the trap/MRET rules.
module tb_istisna_denetleyici;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        istisna_i;
    logic [3:0]  sebep_i;
    logic [31:1] ps_i;
    logic        mret_i;
    logic [11:0] csr_adr_o;
    logic        csr_yaz_o;
    logic [31:0] csr_veri_o;
    logic [31:0] csr_deger_i;
    logic        mesgul_o;
    logic        ps_gecerli_o;
    logic [31:1] ps_yeni_o;
    logic [31:0] istisna_sayisi_o;

    istisna_denetleyici #(.MPP_DEGER(2'b11)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .istisna_i(istisna_i), .sebep_i(sebep_i),
        .ps_i(ps_i), .mret_i(mret_i), .csr_adr_o(csr_adr_o), .csr_yaz_o(csr_yaz_o),
        .csr_veri_o(csr_veri_o), .csr_deger_i(csr_deger_i), .mesgul_o(mesgul_o),
        .ps_gecerli_o(ps_gecerli_o), .ps_yeni_o(ps_yeni_o), .istisna_sayisi_o(istisna_sayisi_o)
    );

    always #5 clk_i = ~clk_i;

    logic [31:0] csr_mem [0:4095];
    logic [43:0] wq[$];
    int tests = 0;
    int fails = 0;
    int ntrap = 0;

    assign csr_deger_i = csr_mem[csr_adr_o];

    // Behaves as the CSR unit: commits a write on the clock edge and logs it.
    always @(posedge clk_i) begin
        if (csr_yaz_o) begin
            csr_mem[csr_adr_o] <= csr_veri_o;
            wq.push_back({csr_adr_o, csr_veri_o});
        end
    end

    task automatic chk(input string tag, input logic [43:0] got, input logic [43:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ms_trap(input logic [31:0] m);
        return (m & ~32'h0000_1888) | (32'(m[3]) << 7) | (32'h3 << 11);
    endfunction

    function automatic logic [31:0] ms_ret(input logic [31:0] m);
        return (m & ~32'h0000_0088) | (32'(m[7]) << 3) | 32'h80;
    endfunction

    function automatic logic [31:0] exp_count();
`ifdef ISTISNA_SAYAC_EN
        return 32'(ntrap);
`else
        return 32'd0;
`endif
    endfunction

    // One request from BOSTA: trap (optionally with a simultaneous MRET) or MRET,
    // with an optional second exception injected during the mcause write cycle.
    task automatic do_seq(input bit is_trap, input bit also_mret, input logic [3:0] sb,
                          input logic [31:1] pc, input bit inject);
        logic [43:0] exp_w[$];
        logic [31:1] tgt;
        int lat;
        exp_w = {};
        if (is_trap) begin
            exp_w.push_back({12'h341, pc, 1'b0});
            exp_w.push_back({12'h342, 28'b0, sb});
            exp_w.push_back({12'h300, ms_trap(csr_mem[12'h300])});
            tgt = {csr_mem[12'h305][31:2], 1'b0};
            lat = 6;
        end else begin
            exp_w.push_back({12'h300, ms_ret(csr_mem[12'h300])});
            tgt = csr_mem[12'h341][31:1];
            lat = 4;
        end
        wq.delete();
        istisna_i = is_trap;
        mret_i = !is_trap || also_mret;
        sebep_i = sb;
        ps_i = pc;
        @(negedge clk_i);
        istisna_i = 1'b0;
        mret_i = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            if (inject && c == 3) begin
                istisna_i = 1'b1;
                mret_i = 1'b1;
                sebep_i = (sb == 4'd2) ? 4'd6 : 4'd2;
                ps_i = ~pc;
            end else begin
                istisna_i = 1'b0;
                mret_i = 1'b0;
            end
            chk($sformatf("mesgul c%0d", c), 44'(mesgul_o), 44'd1);
            chk($sformatf("gecerli c%0d", c), 44'(ps_gecerli_o), 44'(c == lat));
            if (c == lat) begin
                chk("ps_yeni", 44'(ps_yeni_o), 44'(tgt));
                chk("yonlendir adr/veri", {csr_adr_o, csr_veri_o}, 44'd0);
            end
            @(negedge clk_i);
        end
        istisna_i = 1'b0;
        mret_i = 1'b0;
        chk("bosta mesgul", 44'(mesgul_o), 44'd0);
        chk("bosta gecerli", 44'(ps_gecerli_o), 44'd0);
        chk("yazma sayisi", 44'(wq.size()), 44'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < wq.size(); i++)
            chk($sformatf("yazma %0d", i), wq[i], exp_w[i]);
        if (is_trap) ntrap++;
        chk("sayac", 44'(istisna_sayisi_o), 44'(exp_count()));
    endtask

    initial begin
        logic [3:0] causes [6];
        logic [3:0] sb;
        logic [31:1] pc;
        causes = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd6, 4'd11};
        for (int i = 0; i < 4096; i++) csr_mem[i] = 32'd0;
        rst_i = 1'b1;
        istisna_i = 1'b0;
        mret_i = 1'b0;
        sebep_i = 4'd0;
        ps_i = '0;
        @(negedge clk_i);
        chk("reset cikislar", {mesgul_o, ps_gecerli_o, ps_yeni_o, csr_yaz_o, csr_adr_o},
            45'd0 + 44'd0);
        chk("reset veri/sayac", {12'd0, csr_veri_o | istisna_sayisi_o}, 44'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Directed trap with known CSR contents.
        csr_mem[12'h305] = 32'h0000_1003;
        csr_mem[12'h300] = 32'h0000_0008;
        do_seq(1'b1, 1'b0, 4'd11, 31'h4000_0010, 1'b0);
        chk("mstatus tuzak", 44'(csr_mem[12'h300]), 44'h1880);
        chk("mepc", 44'(csr_mem[12'h341]), 44'h8000_0020);

        // MRET back to the faulting PC, accepted right after YONLENDIR.
        do_seq(1'b0, 1'b0, 4'd0, '0, 1'b0);
        chk("mstatus donus", 44'(csr_mem[12'h300]), 44'h1888);

        // Simultaneous trap and MRET: trap only.
        do_seq(1'b1, 1'b1, 4'd4, 31'h0000_0123, 1'b0);
        // Second exception during mcause write is ignored.
        do_seq(1'b1, 1'b0, 4'd3, 31'h0ABC_DEF0, 1'b1);
        chk("mcause ilk", 44'(csr_mem[12'h342]), 44'd3);

        // Reset while in T_MEPC_YAZ.
        wq.delete();
        istisna_i = 1'b1;
        sebep_i = 4'd6;
        ps_i = 31'h1234_5678;
        @(negedge clk_i);
        istisna_i = 1'b0;
        @(negedge clk_i);
        chk("mepc yaz durumu", 44'(csr_yaz_o), 44'd1);
        rst_i = 1'b1;
        #1;
        chk("reset aninda mesgul", 44'(mesgul_o), 44'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("reset sonrasi mesgul", 44'(mesgul_o), 44'd0);
        for (int c = 0; c < 8; c++) begin
            chk("reset sonrasi gecerli", 44'(ps_gecerli_o), 44'd0);
            @(negedge clk_i);
        end
        chk("reset sonrasi yazma yok", 44'(wq.size()), 44'd0);
        ntrap = 0;
        chk("reset sayac", 44'(istisna_sayisi_o), 44'd0);

        // Randomized traps and returns.
        for (int n = 0; n < 12; n++) begin
            sb = causes[$urandom_range(0, 5)];
            pc = 31'($urandom);
            csr_mem[12'h305] = $urandom;
            csr_mem[12'h300] = $urandom;
            do_seq(1'b1, 1'($urandom_range(0, 1)), sb, pc, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) csr_mem[12'h341] = $urandom;
            do_seq(1'b0, 1'b0, 4'd0, '0, 1'b0);
        end

`ifdef ISTISNA_SAYAC_EN
        force dut.sayac = 32'hFFFF_FFFF;
        @(negedge clk_i);
        release dut.sayac;
        @(negedge clk_i);
        ntrap = -1;
        do_seq(1'b1, 1'b0, 4'd2, 31'h10, 1'b0);
        chk("sayac tasma", 44'(istisna_sayisi_o), 44'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $fatal(1, "FAIL timeout");
    end
endmodule

// File: doc/istisna_denetleyici.md
ISTISNA_DENETLEYICI -- requirements
Module: istisna_denetleyici

Interface
REQ-001 SHALL have parameter MPP_DEGER, default 2'b11, the privilege value written to mstatus.MPP on trap entry.
REQ-002 SHALL have port clk_i, input, 1 bit: the only clock, with all state updated on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port istisna_i, input, 1 bit: single-cycle exception request from the execute stage.
REQ-005 SHALL have port sebep_i, input, 4 bits: exception cause code (0, 2, 3, 4, 6 or 11).
REQ-006 SHALL have port ps_i, input, 31 bits [31:1]: PC of the faulting instruction.
REQ-007 SHALL have port mret_i, input, 1 bit: single-cycle MRET request.
REQ-008 SHALL have port csr_adr_o, output, 12 bits: CSR address driven to the CSR unit.
REQ-009 SHALL have port csr_yaz_o, output, 1 bit: CSR write strobe.
REQ-010 SHALL have port csr_veri_o, output, 32 bits: CSR write data.
REQ-011 SHALL have port csr_deger_i, input, 32 bits: CSR read data, returned combinationally in the same cycle as csr_adr_o.
REQ-012 SHALL have port mesgul_o, output, 1 bit: sequence in progress; the pipeline stalls while it is high.
REQ-013 SHALL have port ps_gecerli_o, output, 1 bit: one-cycle redirect valid, which doubles as the pipeline flush.
REQ-014 SHALL have port ps_yeni_o, output, 31 bits [31:1]: redirect target.
REQ-015 SHALL have port istisna_sayisi_o, output, 32 bits: count of completed trap entries.

Function
REQ-016 SHALL implement an FSM with the states BOSTA, T_MSTATUS_OKU, T_MEPC_YAZ, T_MCAUSE_YAZ, T_MSTATUS_YAZ, T_MTVEC_OKU, R_MSTATUS_OKU, R_MSTATUS_YAZ, R_MEPC_OKU and YONLENDIR, each lasting one cycle.
REQ-017 SHALL, in BOSTA with istisna_i high, latch sebep_i and ps_i and go to T_MSTATUS_OKU.
REQ-018 SHALL walk the trap path in this order: T_MSTATUS_OKU -> T_MEPC_YAZ -> T_MCAUSE_YAZ -> T_MSTATUS_YAZ -> T_MTVEC_OKU -> YONLENDIR -> BOSTA.
REQ-019 SHALL, in BOSTA with mret_i high and istisna_i low, go to R_MSTATUS_OKU, then walk R_MSTATUS_OKU -> R_MSTATUS_YAZ -> R_MEPC_OKU -> YONLENDIR -> BOSTA.
REQ-020 SHALL give istisna_i priority when istisna_i and mret_i are high in the same cycle; the MRET is dropped.
REQ-021 SHALL ignore istisna_i and mret_i in every state other than BOSTA.
REQ-022 SHALL, in T_MSTATUS_OKU and R_MSTATUS_OKU, drive csr_adr_o=12'h300 and capture csr_deger_i into an internal mstatus copy.
REQ-023 SHALL, in T_MEPC_YAZ, drive csr_yaz_o=1, csr_adr_o=12'h341 and csr_veri_o={latched ps,1'b0}.
REQ-024 SHALL, in T_MCAUSE_YAZ, drive csr_yaz_o=1, csr_adr_o=12'h342 and csr_veri_o={28'b0,latched sebep}.
REQ-025 SHALL, in T_MSTATUS_YAZ, drive csr_yaz_o=1, csr_adr_o=12'h300 and write the copy with bit7 (MPIE) = old bit3, bit3 (MIE) = 0, bits[12:11] = MPP_DEGER, and all other bits unchanged.
REQ-026 SHALL, in R_MSTATUS_YAZ, drive csr_yaz_o=1, csr_adr_o=12'h300 and write the copy with bit3 = old bit7, bit7 = 1, and all other bits unchanged.
REQ-027 SHALL, in T_MTVEC_OKU (12'h305), register the target as {csr_deger_i[31:2],1'b0}, i.e. direct mode with mtvec[1:0] ignored.
REQ-028 SHALL, in R_MEPC_OKU (12'h341), register the target as csr_deger_i[31:1].
REQ-029 SHALL, in YONLENDIR, assert ps_gecerli_o=1 for exactly one cycle with ps_yeni_o equal to the registered target.
REQ-030 SHALL hold csr_yaz_o=0 outside the write states, and hold csr_adr_o=0 and csr_veri_o=0 in BOSTA and YONLENDIR.
REQ-031 SHALL drive mesgul_o=1 in every state except BOSTA.
REQ-032 SHALL have a latency of 6 cycles from an accepted exception to ps_gecerli_o, and 4 cycles from an accepted MRET.
REQ-033 SHALL allow a new request sampled in the cycle following YONLENDIR (state BOSTA) to be accepted immediately.

Reset
REQ-034 SHALL, on rst_i, immediately force state=BOSTA and drive mesgul_o=0, ps_gecerli_o=0, ps_yeni_o=0, csr_yaz_o=0, csr_adr_o=0, csr_veri_o=0 and istisna_sayisi_o=0.
REQ-035 SHALL, when reset arrives mid-sequence, abandon the sequence with no further CSR writes and no redirect.

Configuration
REQ-036 SHALL, with macro ISTISNA_SAYAC_EN defined, increment istisna_sayisi_o by 1 when leaving T_MSTATUS_YAZ, wrapping 32'hFFFFFFFF -> 0.
REQ-037 SHALL, without ISTISNA_SAYAC_EN, tie istisna_sayisi_o to constant 0 with no counter flops.

Verification
REQ-038 SHALL cover: istisna_i, sebep_i=11, ps_i=31'h4000_0010, mtvec=32'h0000_1003, mstatus=32'h8 -> writes mepc=32'h8000_0020, mcause=11, mstatus=32'h1880; after 6 cycles ps_gecerli_o=1 with ps_yeni_o=31'h800, i.e. target 32'h1000.
REQ-039 SHALL cover: mret_i with mepc=32'h8000_0020 and mstatus=32'h1880 -> mstatus written 32'h1888; after 4 cycles ps_yeni_o=31'h4000_0010.
REQ-040 SHALL cover: istisna_i and mret_i high in the same cycle -> trap sequence only and exactly 3 CSR writes.
REQ-041 SHALL cover: a second istisna_i during T_MCAUSE_YAZ -> ignored, with mcause keeping its first value.
REQ-042 SHALL cover: rst_i pulsed during T_MEPC_YAZ -> next cycle mesgul_o=0, no mcause write and no ps_gecerli_o.
REQ-043 SHALL cover, with ISTISNA_SAYAC_EN: 3 traps -> istisna_sayisi_o=3; counter preloaded to 32'hFFFFFFFF plus one trap -> 0.
